// File: rtl/unsort4_if.sv
// Handshake and data bundle for the unsort4 scatter engine.
// The master drives input tuples and the consumer's ready; the slave (the engine)
// returns the restored words together with the permutation error flag.
interface unsort4_if #(
    parameter int t = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [t:0]   sa;
    logic [t:0]   sb;
    logic [t:0]   sc;
    logic [t:0]   sd;
    logic [7:0]   rank;
    logic         out_valid;
    logic         out_ready;
    logic [t:0]   ra;
    logic [t:0]   rb;
    logic [t:0]   rc;
    logic [t:0]   rd;
    logic         perm_err;

    modport master (
        output in_valid, sa, sb, sc, sd, rank, out_ready,
        input  in_ready, out_valid, ra, rb, rc, rd, perm_err
    );

    modport slave (
        input  in_valid, sa, sb, sc, sd, rank, out_ready,
        output in_ready, out_valid, ra, rb, rc, rd, perm_err
    );
endinterface

// File: rtl/unsort4.sv
// unsort4: restores four sorted words to their original order.
// Accepts a tuple in IDLE, writes one restored word per cycle in SCATTER
// (r_k = s[rank_k]), then presents the result in DONE until the consumer takes it.
// Duplicate rank indices are scattered as given and reported via perm_err.
module unsort4 #(
    parameter int t = 3
) (
    input  logic      clk,
    input  logic      rst,
    unsort4_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCATTER = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [t:0]  s_in [4];
    logic [t:0]  s_reg [4];
    logic [t:0]  r_reg [4];
    logic [7:0]  rank_reg;
    logic [3:0]  seen_reg;
    logic        perm_err_reg;
    logic [1:0]  k_reg;

    logic [1:0]  rank_k;
    logic [3:0]  rank_onehot;
    logic        in_ready_comb;
    logic        out_valid_comb;
    logic        accept;

    assign s_in[0] = bus.sa;
    assign s_in[1] = bus.sb;
    assign s_in[2] = bus.sc;
    assign s_in[3] = bus.sd;

    // Sorted index of the word being restored this cycle, and its one-hot form.
    assign rank_k      = rank_reg[{k_reg, 1'b0} +: 2];
    assign rank_onehot = 4'b0001 << rank_k;

    // in_ready is forced low for as long as reset is asserted.
    assign bus.in_ready  = in_ready_comb & ~rst;
    assign bus.out_valid = out_valid_comb;
    assign bus.perm_err  = perm_err_reg;
    assign bus.ra        = r_reg[0];
    assign bus.rb        = r_reg[1];
    assign bus.rc        = r_reg[2];
    assign bus.rd        = r_reg[3];

    assign accept = (state_reg == IDLE) && bus.in_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next     = state_reg;
        in_ready_comb  = 1'b0;
        out_valid_comb = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_comb = 1'b1;
                if (bus.in_valid) begin
                    state_next = SCATTER;
                end
            end
            SCATTER: begin
                if (k_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_comb = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-word storage: latch sorted inputs on accept, scatter one word per cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_reg[gi] <= '0;
                r_reg[gi] <= '0;
            end else if (accept) begin
                s_reg[gi] <= s_in[gi];
                r_reg[gi] <= '0;
            end else if (state_reg == SCATTER && k_reg == 2'(gi)) begin
                r_reg[gi] <= s_reg[rank_k];
            end
        end
    end

    // Rank tag, scatter counter and duplicate-index tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rank_reg     <= '0;
            seen_reg     <= '0;
            perm_err_reg <= 1'b0;
            k_reg        <= '0;
        end else if (accept) begin
            rank_reg     <= bus.rank;
            seen_reg     <= '0;
            perm_err_reg <= 1'b0;
            k_reg        <= '0;
        end else if (state_reg == SCATTER) begin
            seen_reg <= seen_reg | rank_onehot;
            k_reg    <= k_reg + 2'd1;
            if (k_reg == 2'd3) begin
                perm_err_reg <= ((seen_reg | rank_onehot) != 4'b1111);
            end
        end
    end

endmodule
